// File: rtl/div_quotient_corrector.sv
// Purpose : corrects an approximate DW.DW quotient to floor(xin*2^DW/yin) by unit steps.
// Latency : T+1 for yin==0, else T+2+k (k = correction steps, capped at MAX_STEPS).
// Backpr. : one op in flight; in_ready only in IDLE; result held in DONE until out_ready.
// Optional: define DIVCORR_REM_EN to expose the final remainder on rem_out.
module div_quotient_corrector #(
   parameter int MAX_STEPS = 255,
   parameter int DW        = 8
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [DW-1:0]   xin,
   input  logic [DW-1:0]   yin,
   input  logic [2*DW-1:0] q_in,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [2*DW-1:0] q_out,
`ifdef DIVCORR_REM_EN
   output logic [DW-1:0]   rem_out,
`endif
   output logic            div_zero,
   output logic            inexact
);

   localparam int QW = 2 * DW;
   localparam int RW = 3 * DW + 1;
   localparam logic [7:0] MAX_C = 8'(MAX_STEPS);

   typedef enum logic [1:0] {IDLE, CALC, ADJ, DONE} state_t;

   state_t                state_q, state_d;
   logic                  rdy_q, rdy_d;
   logic [DW-1:0]         x_q, x_d;
   logic [DW-1:0]         y_q, y_d;
   logic signed [QW:0]    q_q, q_d;     // one extra bit so 0-1 stays negative
   logic signed [RW-1:0]  r_q, r_d;
   logic [7:0]            cnt_q, cnt_d;
   logic [QW-1:0]         qout_q, qout_d;
   logic                  dz_q, dz_d;
   logic                  inx_q, inx_d;
`ifdef DIVCORR_REM_EN
   logic [DW-1:0]         rem_q, rem_d;
`endif

   logic signed [RW-1:0]  num_s, y_s, prod_s, r_calc, r_step;
   logic signed [QW:0]    q_step;
   logic [7:0]            cnt_inc;
   logic                  calc_ok, step_ok;

   // Datapath: initial residual (only consumed in CALC) and one unit step from the held residual.
   always_comb begin
      num_s   = $signed({{(DW+1){1'b0}}, x_q, {DW{1'b0}}});
      y_s     = $signed({{(RW-DW){1'b0}}, y_q});
      prod_s  = $signed({{(RW-QW-1){q_q[QW]}}, q_q}) * y_s;
      r_calc  = num_s - prod_s;
      if (r_q[RW-1]) begin
         q_step = q_q - $signed({{QW{1'b0}}, 1'b1});
         r_step = r_q + y_s;
      end else begin
         q_step = q_q + $signed({{QW{1'b0}}, 1'b1});
         r_step = r_q - y_s;
      end
      calc_ok = !r_calc[RW-1] && (r_calc < y_s);
      step_ok = !r_step[RW-1] && (r_step < y_s);
      cnt_inc = cnt_q + 8'd1;
   end

   // Next-state and result capture; results are registered on entry to DONE.
   always_comb begin
      state_d = state_q;
      x_d     = x_q;
      y_d     = y_q;
      q_d     = q_q;
      r_d     = r_q;
      cnt_d   = cnt_q;
      qout_d  = qout_q;
      dz_d    = dz_q;
      inx_d   = inx_q;
`ifdef DIVCORR_REM_EN
      rem_d   = rem_q;
`endif
      case (state_q)
         IDLE: begin
            if (in_valid && rdy_q) begin
               x_d   = xin;
               y_d   = yin;
               q_d   = $signed({1'b0, q_in});
               cnt_d = 8'd0;
               inx_d = 1'b0;
               if (yin == '0) begin
                  state_d = DONE;
                  qout_d  = '1;
                  dz_d    = 1'b1;
`ifdef DIVCORR_REM_EN
                  rem_d   = xin;
`endif
               end else begin
                  state_d = CALC;
                  dz_d    = 1'b0;
               end
            end
         end
         CALC: begin
            r_d = r_calc;
            if (calc_ok) begin
               state_d = DONE;
               qout_d  = q_q[QW-1:0];
`ifdef DIVCORR_REM_EN
               rem_d   = r_calc[DW-1:0];
`endif
            end else begin
               state_d = ADJ;
            end
         end
         ADJ: begin
            q_d   = q_step;
            r_d   = r_step;
            cnt_d = cnt_inc;
            if (step_ok || cnt_inc == MAX_C) begin
               state_d = DONE;
               qout_d  = q_step[QW-1:0];
               inx_d   = !step_ok;
`ifdef DIVCORR_REM_EN
               rem_d   = r_step[DW-1:0];
`endif
            end
         end
         DONE: begin
            if (out_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
      rdy_d = (state_d == IDLE);
   end

   // State and datapath registers; reset aborts any operation in flight.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         rdy_q   <= 1'b0;
         x_q     <= '0;
         y_q     <= '0;
         q_q     <= '0;
         r_q     <= '0;
         cnt_q   <= '0;
         qout_q  <= '0;
         dz_q    <= 1'b0;
         inx_q   <= 1'b0;
`ifdef DIVCORR_REM_EN
         rem_q   <= '0;
`endif
      end else begin
         state_q <= state_d;
         rdy_q   <= rdy_d;
         x_q     <= x_d;
         y_q     <= y_d;
         q_q     <= q_d;
         r_q     <= r_d;
         cnt_q   <= cnt_d;
         qout_q  <= qout_d;
         dz_q    <= dz_d;
         inx_q   <= inx_d;
`ifdef DIVCORR_REM_EN
         rem_q   <= rem_d;
`endif
      end
   end

   assign in_ready  = rdy_q;
   assign out_valid = (state_q == DONE);
   assign q_out     = qout_q;
   assign div_zero  = dz_q;
   assign inexact   = inx_q;
`ifdef DIVCORR_REM_EN
   assign rem_out   = rem_q;
`endif

endmodule
